// File: rtl/video_fetch_pkg.sv
// Shared types and constants for the video fetch requester.
//   fetch_state_t : fetch FSM states (idle, bitmap phase, attribute phase, done)
//   ATTR_BASE     : attribute area selector bits within the 16Kb video page
package video_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBmp,
    StAttr,
    StDone
  } fetch_state_t;

  localparam logic [2:0] ATTR_BASE = 3'b110;

endpackage

// File: rtl/video_fetch_addr.sv
// Combinational ULA address generator: cell coordinates -> page-relative addresses.
// Ports:
//   y           in  8   screen line, 0..191
//   x           in  5   cell column, 0..31
//   bitmap_addr out 15  pixel byte address (thirds / char-row / pixel-row interleave)
//   attr_addr   out 15  attribute byte address
module video_fetch_addr
  import video_fetch_pkg::*;
(
  input  logic [7:0]  y,
  input  logic [4:0]  x,
  output logic [14:0] bitmap_addr,
  output logic [14:0] attr_addr
);

  // Pixel row within a character cell sits above the character row.
  assign bitmap_addr = {2'b00, y[7:6], y[2:0], y[5:3], x};
  assign attr_addr   = {2'b00, ATTR_BASE, y[7:3], x};

endmodule

// File: rtl/video_fetch.sv
// Video read requester: fetches bitmap and attribute bytes of one cell through the
// arbiter req/ack/valid channel and double-buffers them for the pixel shifter.
// Optional feature macro: VIDEO_FETCH_FLOATBUS_EN (floating-bus value and window).
// Ports:
//   clk28, rst_n                         clock, synchronous active-low reset
//   fetch_start, fetch_y, fetch_x        start a cell fetch at (line, column)
//   video_read_req/addr                  request and address to the arbiter
//   video_read_req_ack, video_data_valid arbiter handshake; vd is the SRAM data bus
//   load                                 shifter takes the buffered cell
//   bitmap_out, attr_out, out_valid      front buffer
//   busy, underrun                       FSM not idle, sticky protocol/timing error
//   floatbus_data, floatbus_active       floating-bus value and window
module video_fetch
  import video_fetch_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic [7:0]  fetch_y,
  input  logic [4:0]  fetch_x,
  output logic        video_read_req,
  output logic [14:0] video_read_addr,
  input  logic        video_read_req_ack,
  input  logic        video_data_valid,
  input  logic [7:0]  vd,
  input  logic        load,
  output logic [7:0]  bitmap_out,
  output logic [7:0]  attr_out,
  output logic        out_valid,
  output logic        busy,
  output logic        underrun,
  output logic [7:0]  floatbus_data,
  output logic        floatbus_active
);

  localparam int unsigned     CntW    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  fetch_state_t    state_q;
  logic [7:0]      y_q;
  logic [4:0]      x_q;
  logic            ack_seen_q;
  logic [CntW-1:0] cnt_q;
  logic            pending_q;
  logic [7:0]      bmp_back_q, attr_back_q;
  logic [7:0]      bitmap_q, attr_q;
  logic            out_valid_q, underrun_q;

  logic [14:0] bitmap_addr, attr_addr;
  logic        in_phase, data_take, ack_expire;

  video_fetch_addr u_addr (
    .y           (y_q),
    .x           (x_q),
    .bitmap_addr (bitmap_addr),
    .attr_addr   (attr_addr)
  );

  assign in_phase   = (state_q == StBmp) || (state_q == StAttr);
  // Data is only accepted once the arbiter acknowledged this phase's address.
  assign data_take  = in_phase && ack_seen_q && video_data_valid;
  // Ack in the final allowed cycle still wins over the timeout.
  assign ack_expire = in_phase && !ack_seen_q && !video_read_req_ack && (cnt_q == CntLast);

  // Lookahead: in the bitmap valid cycle the attribute address is already presented,
  // and in the attribute valid cycle the request is already withdrawn.
  always_comb begin
    video_read_req  = 1'b0;
    video_read_addr = '0;
    unique case (state_q)
      StBmp: begin
        video_read_req  = 1'b1;
        video_read_addr = data_take ? attr_addr : bitmap_addr;
      end
      StAttr: begin
        video_read_req  = !data_take;
        video_read_addr = attr_addr;
      end
      default: ;
    endcase
    // Drop the request in the very cycle reset is applied.
    video_read_req = video_read_req && rst_n;
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      y_q         <= '0;
      x_q         <= '0;
      ack_seen_q  <= 1'b0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      bmp_back_q  <= '0;
      attr_back_q <= '0;
      bitmap_q    <= '0;
      attr_q      <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      if (in_phase && video_read_req_ack) begin
        ack_seen_q <= 1'b1;
        cnt_q      <= '0;
      end else if (in_phase && !ack_seen_q) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (load && state_q != StDone) begin
        out_valid_q <= 1'b0;
        if (in_phase) underrun_q <= 1'b1;
      end
      if (fetch_start && in_phase) underrun_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pending_q || fetch_start) begin
            state_q    <= StBmp;
            ack_seen_q <= 1'b0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            if (pending_q && fetch_start) begin
              underrun_q <= 1'b1;
            end else if (!pending_q) begin
              y_q <= fetch_y;
              x_q <= fetch_x;
            end
          end
        end
        StBmp, StAttr: begin
          if (ack_expire) begin
            underrun_q <= 1'b1;
            state_q    <= StIdle;
          end else if (data_take) begin
            ack_seen_q <= 1'b0;
            cnt_q      <= '0;
            if (state_q == StBmp) begin
              bmp_back_q <= vd;
              state_q    <= StAttr;
            end else begin
              attr_back_q <= vd;
              state_q     <= StDone;
            end
          end
        end
        StDone: begin
          if (load) begin
            bitmap_q    <= bmp_back_q;
            attr_q      <= attr_back_q;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
            // Start arriving with the load is held for the following cycle.
            if (fetch_start) begin
              pending_q <= 1'b1;
              y_q       <= fetch_y;
              x_q       <= fetch_x;
            end
          end else if (fetch_start) begin
            underrun_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bitmap_out = bitmap_q;
  assign attr_out   = attr_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != StIdle);
  assign underrun   = underrun_q;

`ifdef VIDEO_FETCH_FLOATBUS_EN
  logic [7:0] fb_data_q;
  logic       fb_active_q, fb_clr_q;

  // Window opens on the cell's first data byte and closes one cycle after load.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      fb_data_q   <= 8'hFF;
      fb_active_q <= 1'b0;
      fb_clr_q    <= 1'b0;
    end else begin
      if (data_take) fb_data_q <= vd;
      if (fb_clr_q) begin
        fb_active_q <= 1'b0;
        fb_clr_q    <= 1'b0;
      end
      if (data_take && state_q == StBmp) fb_active_q <= 1'b1;
      if (ack_expire) fb_active_q <= 1'b0;
      if (load && state_q == StDone) fb_clr_q <= 1'b1;
    end
  end

  assign floatbus_data   = fb_data_q;
  assign floatbus_active = fb_active_q;
`else
  assign floatbus_data   = 8'hFF;
  assign floatbus_active = 1'b0;
`endif

endmodule

// File: tb/tb_video_fetch.sv
// Directed self-checking bench for video_fetch; the bench plays the arbiter.
// Honours VIDEO_FETCH_FLOATBUS_EN for the floating-bus expectations.
module tb_video_fetch;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        fetch_start;
  logic [7:0]  fetch_y;
  logic [4:0]  fetch_x;
  logic        video_read_req;
  logic [14:0] video_read_addr;
  logic        video_read_req_ack;
  logic        video_data_valid;
  logic [7:0]  vd;
  logic        load;
  logic [7:0]  bitmap_out, attr_out;
  logic        out_valid, busy, underrun;
  logic [7:0]  floatbus_data;
  logic        floatbus_active;

  logic [7:0]  a_y;
  logic [4:0]  a_x;
  logic [14:0] a_bmp, a_attr;

  int checks = 0;
  int errors = 0;

  always #18 clk28 = ~clk28;

  video_fetch #(.ACK_TIMEOUT(15)) dut (
    .clk28              (clk28),
    .rst_n              (rst_n),
    .fetch_start        (fetch_start),
    .fetch_y            (fetch_y),
    .fetch_x            (fetch_x),
    .video_read_req     (video_read_req),
    .video_read_addr    (video_read_addr),
    .video_read_req_ack (video_read_req_ack),
    .video_data_valid   (video_data_valid),
    .vd                 (vd),
    .load               (load),
    .bitmap_out         (bitmap_out),
    .attr_out           (attr_out),
    .out_valid          (out_valid),
    .busy               (busy),
    .underrun           (underrun),
    .floatbus_data      (floatbus_data),
    .floatbus_active    (floatbus_active)
  );

  video_fetch_addr u_addr_unit (
    .y           (a_y),
    .x           (a_x),
    .bitmap_addr (a_bmp),
    .attr_addr   (a_attr)
  );

  task automatic apply_reset();
    rst_n = 1'b0; fetch_start = 1'b0; fetch_y = '0; fetch_x = '0;
    video_read_req_ack = 1'b0; video_data_valid = 1'b0; vd = '0; load = 1'b0;
    @(negedge clk28);
    @(negedge clk28);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the FSM idle; returns at the first bitmap-phase negedge.
  task automatic start_cell(input logic [7:0] y, input logic [4:0] x);
    fetch_start = 1'b1; fetch_y = y; fetch_x = x;
    @(negedge clk28);
    fetch_start = 1'b0;
  endtask

  // One phase: n_wait cycles without ack, one ack cycle, one valid cycle.
  task automatic do_phase(input string name, input logic [14:0] exp_addr, input int n_wait,
                          input logic [7:0] data, input logic last,
                          input logic [14:0] next_addr);
    int bad = 0;
    for (int i = 0; i <= n_wait; i++) begin
      video_read_req_ack = (i == n_wait);
      #1;
      if (video_read_req !== 1'b1 || video_read_addr !== exp_addr || busy !== 1'b1) bad++;
      @(negedge clk28);
    end
    video_read_req_ack = 1'b0; video_data_valid = 1'b1; vd = data;
    #1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_hold: last req=%b addr=%h, required req=1 addr=%h (%0d bad cycles)",
               name, video_read_req, video_read_addr, exp_addr, bad);
    end
    checks++;
    if (last ? (video_read_req !== 1'b0)
             : (video_read_req !== 1'b1 || video_read_addr !== next_addr)) begin
      errors++;
      $display("FAIL %s_lookahead: req=%b addr=%h, required req=%b addr=%h",
               name, video_read_req, video_read_addr, !last, next_addr);
    end
    @(negedge clk28);
    video_data_valid = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    @(negedge clk28);
    load = 1'b0;
    #1;
  endtask

  task automatic check_front(input string name, input logic [7:0] b, input logic [7:0] a,
                             input logic v);
    checks++;
    if (bitmap_out !== b || attr_out !== a || out_valid !== v) begin
      errors++;
      $display("FAIL %s: bmp=%h attr=%h valid=%b, required bmp=%h attr=%h valid=%b",
               name, bitmap_out, attr_out, out_valid, b, a, v);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (video_read_req !== 1'b0 || video_read_addr !== 15'h0 || busy !== 1'b0 ||
        underrun !== 1'b0 || floatbus_data !== 8'hFF || floatbus_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%h busy=%b underrun=%b fb=%h/%b, required 0 0 0 0 ff/0",
               video_read_req, video_read_addr, busy, underrun, floatbus_data, floatbus_active);
    end
    check_front("reset_front", 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_addr_unit();
    logic [7:0]  ty [3] = '{8'd0, 8'd100, 8'd191};
    logic [4:0]  tx [3] = '{5'd0, 5'd10, 5'd31};
    logic [14:0] tb [3] = '{15'h0000, 15'h0C8A, 15'h17FF};
    logic [14:0] ta [3] = '{15'h1800, 15'h198A, 15'h1AFF};
    for (int i = 0; i < 3; i++) begin
      a_y = ty[i]; a_x = tx[i];
      #1;
      checks++;
      if (a_bmp !== tb[i] || a_attr !== ta[i]) begin
        errors++;
        $display("FAIL addr_unit_%0d: bmp=%h attr=%h, required bmp=%h attr=%h",
                 i, a_bmp, a_attr, tb[i], ta[i]);
      end
    end
  endtask

  task automatic test_basic();
    start_cell(8'd0, 5'd0);
    do_phase("basic_bmp", 15'h0000, 1, 8'hAA, 1'b0, 15'h1800);
    do_phase("basic_attr", 15'h1800, 1, 8'h55, 1'b1, 15'h0000);
    #1;
    checks++;
    if (busy !== 1'b1 || video_read_req !== 1'b0 || video_read_addr !== 15'h0) begin
      errors++;
      $display("FAIL basic_done: busy=%b req=%b addr=%h, required busy=1 req=0 addr=0000",
               busy, video_read_req, video_read_addr);
    end
`ifdef VIDEO_FETCH_FLOATBUS_EN
    checks++;
    if (floatbus_data !== 8'h55 || floatbus_active !== 1'b1) begin
      errors++;
      $display("FAIL fb_done: fb=%h/%b, required 55/1", floatbus_data, floatbus_active);
    end
`endif
    do_load();
    check_front("basic_load", 8'hAA, 8'h55, 1'b1);
    checks++;
    if (busy !== 1'b0 || floatbus_active !== `ifdef VIDEO_FETCH_FLOATBUS_EN 1'b1 `else 1'b0 `endif) begin
      errors++;
      $display("FAIL basic_after_load: busy=%b fb_active=%b", busy, floatbus_active);
    end
    @(negedge clk28);
    #1;
    checks++;
    if (floatbus_active !== 1'b0) begin
      errors++;
      $display("FAIL fb_close: fb_active=%b, required 0", floatbus_active);
    end
  endtask

  task automatic test_coords();
    start_cell(8'd100, 5'd10);
    do_phase("c100_bmp", 15'h0C8A, 1, 8'h11, 1'b0, 15'h198A);
    do_phase("c100_attr", 15'h198A, 1, 8'h22, 1'b1, 15'h0000);
    do_load();
    check_front("c100_load", 8'h11, 8'h22, 1'b1);
    start_cell(8'd191, 5'd31);
    do_phase("c191_bmp", 15'h17FF, 1, 8'h33, 1'b0, 15'h1AFF);
    do_phase("c191_attr", 15'h1AFF, 1, 8'h44, 1'b1, 15'h0000);
    do_load();
    check_front("c191_load", 8'h33, 8'h44, 1'b1);
  endtask

  task automatic test_contention();
    start_cell(8'd100, 5'd10);
    do_phase("cont_bmp", 15'h0C8A, 5, 8'h5A, 1'b0, 15'h198A);
    do_phase("cont_attr", 15'h198A, 5, 8'hA5, 1'b1, 15'h0000);
    do_load();
    check_front("cont_load", 8'h5A, 8'hA5, 1'b1);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL cont_underrun: underrun=%b, required 0", underrun);
    end
  endtask

  task automatic test_valid_before_ack();
    // Valid without a prior ack must be ignored and must not latch.
    start_cell(8'd0, 5'd1);
    video_data_valid = 1'b1; vd = 8'hEE;
    @(negedge clk28);
    video_data_valid = 1'b0;
    do_phase("early_bmp", 15'h0001, 0, 8'h01, 1'b0, 15'h1801);
    do_phase("early_attr", 15'h1801, 1, 8'h02, 1'b1, 15'h0000);
    do_load();
    check_front("early_load", 8'h01, 8'h02, 1'b1);
  endtask

  task automatic test_timeout();
    int bad = 0;
    start_cell(8'd100, 5'd10);
    for (int i = 1; i <= 15; i++) begin
      #1;
      if (video_read_req !== 1'b1 || video_read_addr !== 15'h0C8A || busy !== 1'b1) bad++;
      @(negedge clk28);
    end
    #1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_hold: %0d bad cycles before abort", bad);
    end
    checks++;
    if (busy !== 1'b0 || underrun !== 1'b1 || video_read_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: busy=%b underrun=%b req=%b, required 0 1 0",
               busy, underrun, video_read_req);
    end
    check_front("timeout_front", 8'h01, 8'h02, 1'b1);
  endtask

  task automatic test_load_outside();
    do_load();
    check_front("idle_load", 8'h01, 8'h02, 1'b0);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_load_underrun: underrun=%b, required 0", underrun);
    end
  endtask

  task automatic test_start_while_busy();
    start_cell(8'd100, 5'd10);
    fetch_start = 1'b1; fetch_y = 8'd5; fetch_x = 5'd3;
    @(negedge clk28);
    fetch_start = 1'b0;
    do_phase("busy_bmp", 15'h0C8A, 0, 8'h77, 1'b0, 15'h198A);
    do_phase("busy_attr", 15'h198A, 1, 8'h88, 1'b1, 15'h0000);
    do_load();
    check_front("busy_load", 8'h77, 8'h88, 1'b1);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL busy_underrun: underrun=%b, required 1", underrun);
    end
  endtask

  task automatic test_back_to_back();
    start_cell(8'd0, 5'd0);
    do_phase("b2b_bmp0", 15'h0000, 1, 8'hC1, 1'b0, 15'h1800);
    do_phase("b2b_attr0", 15'h1800, 1, 8'hC2, 1'b1, 15'h0000);
    fetch_start = 1'b1; fetch_y = 8'd191; fetch_x = 5'd31;
    do_load();
    fetch_start = 1'b0;
    check_front("b2b_load", 8'hC1, 8'hC2, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b, required 0", busy);
    end
    @(negedge clk28);
    do_phase("b2b_bmp1", 15'h17FF, 1, 8'hD1, 1'b0, 15'h1AFF);
    do_phase("b2b_attr1", 15'h1AFF, 1, 8'hD2, 1'b1, 15'h0000);
    do_load();
    check_front("b2b_load1", 8'hD1, 8'hD2, 1'b1);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_underrun: underrun=%b, required 0", underrun);
    end
  endtask

  task automatic test_reset_mid();
    start_cell(8'd100, 5'd10);
    do_phase("rst_bmp", 15'h0C8A, 1, 8'h99, 1'b0, 15'h198A);
    rst_n = 1'b0;
    #1;
    checks++;
    if (video_read_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_same: req=%b, required 0", video_read_req);
    end
    @(negedge clk28);
    #1;
    checks++;
    if (video_read_req !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        floatbus_data !== 8'hFF || floatbus_active !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: req=%b busy=%b valid=%b fb=%h/%b, required 0 0 0 ff/0",
               video_read_req, busy, out_valid, floatbus_data, floatbus_active);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addr_unit();
    test_basic();
    test_coords();
    test_contention();
    test_valid_before_ack();
    test_load_outside();
    test_reset();
    start_cell(8'd0, 5'd1);
    do_phase("pre_bmp", 15'h0001, 1, 8'h01, 1'b0, 15'h1801);
    do_phase("pre_attr", 15'h1801, 1, 8'h02, 1'b1, 15'h0000);
    do_load();
    test_timeout();
    test_reset();
    test_start_while_busy();
    test_reset();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk28);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_fetch.md
Name: video_fetch

Overview:
- Requester side of the arbiter's video read channel. Converts ULA cell coordinates (line, column) into bitmap and attribute addresses within the 16Kb video page, and runs the req/ack/valid handshake.
- Captures both bytes from the SRAM data bus and double-buffers them for the pixel shifter.
- Sits between the video timing/shifter logic and the memory arbiter.

Parameters:
- ACK_TIMEOUT, 15: clk28 cycles allowed from request assertion to video_read_req_ack before the cell is aborted.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  reset, synchronous, active-low
- fetch_start  in  1  one-cycle pulse: begin fetching the cell at fetch_y/fetch_x
- fetch_y  in  8  screen line, 0..191
- fetch_x  in  5  cell column, 0..31
- video_read_req  out  1  request to arbiter
- video_read_addr  out  15  page-relative address
- video_read_req_ack  in  1  arbiter accepted the current address
- video_data_valid  in  1  vd holds data for the accepted address
- vd  in  8  SRAM data bus, sampled only when video_data_valid=1
- load  in  1  shifter takes the buffered cell (pulse)
- bitmap_out  out  8  front-buffer pixel byte
- attr_out  out  8  front-buffer attribute byte
- out_valid  out  1  front buffer loaded by the last load
- busy  out  1  FSM not IDLE
- underrun  out  1  sticky error flag, cleared by reset only
- floatbus_data  out  8  floating-bus value
- floatbus_active  out  1  floating-bus window

Behaviour:
- Address computation: coordinates are latched on fetch_start into y_r and x_r.
  - Bitmap address = {2'b00, y_r[7:6], y_r[2:0], y_r[5:3], x_r}.
  - Attribute address = {2'b00, 3'b110, y_r[7:3], x_r}.
- FSM states: IDLE, BMP, ATTR, DONE.
- IDLE:
  - fetch_start → BMP.
  - req=0, addr=0.
- BMP:
  - req=1, addr=bitmap.
  - Once ack has been seen, wait for video_data_valid.
  - On valid: latch vd into bmp_back, go to ATTR.
  - In the valid cycle, addr already shows the attribute address (combinational lookahead) and req stays 1. The arbiter re-arms on this address with no idle cycle.
- ATTR:
  - Same sequence as BMP. On valid, latch vd into attr_back and go to DONE.
  - In the valid cycle req drops to 0 (lookahead).
- DONE:
  - Back buffer is full.
  - load → copy back to front, set out_valid=1, go to IDLE.
- req and addr must never change between req assertion and the matching valid cycle, except for the lookahead above.
- valid is ignored unless ack was seen for the current phase. A valid before ack is a protocol error: ignore it, do not latch.
- Timeout: counter cleared on each phase entry and on ack. On reaching ACK_TIMEOUT without ack, set underrun and go to IDLE. Back buffer is not updated.
- fetch_start while busy: ignored, underrun set.
- load outside DONE:
  - Front buffer is not changed; out_valid cleared to 0.
  - If in BMP or ATTR, underrun is set.
- load and fetch_start in the same cycle while in DONE: load completes, then the next fetch starts in the following cycle. The fetch_start is not lost; one pending-start bit holds it.
- Reset values:
  - video_read_req=0, video_read_addr=0.
  - bitmap_out=0, attr_out=0.
  - out_valid=0, busy=0, underrun=0.
  - floatbus_data=8'hFF, floatbus_active=0.
  - FSM returns to IDLE. Reset mid-fetch drops req in the same cycle reset is sampled.
- Latency with the arbiter idle: fetch_start → DONE in 1 + 3 + 3 cycles.

Optional Feature:
- Macro VIDEO_FETCH_FLOATBUS_EN.
- Defined:
  - floatbus_data = last byte latched from vd (bitmap or attribute).
  - floatbus_active=1 from the first valid of a cell until the cycle after load; 0 otherwise.
- Undefined: floatbus_data tied to 8'hFF, floatbus_active tied to 0; no extra registers.

Decomposition:
- Package common gets fetch_state_t (IDLE/BMP/ATTR/DONE) and the constant ATTR_BASE = 3'b110.
- One natural sub-module, video_fetch_addr: purely combinational, y/x → bitmap and attribute addresses. Tested standalone.

Test Plan:
- Idle arbiter (ack 1 cycle after req, valid 1 cycle after ack), y=0, x=0, vd 8'hAA then 8'h55 → addrs 0x0000 then 0x1800; after load, bitmap_out=AA, attr_out=55, out_valid=1.
- y=100, x=10 → bitmap 0x0C8A, attr 0x198A. y=191, x=31 → 0x17FF, 0x1AFF.
- Ack withheld for 5 cycles (contention) → req and addr stable throughout, then normal completion; underrun stays 0.
- Ack withheld for 16 cycles → underrun=1, FSM IDLE, front buffer unchanged.
- fetch_start during BMP → underrun=1, first cell completes with the original coordinates.
- Reset asserted in ATTR → next cycle req=0, busy=0, out_valid=0. With VIDEO_FETCH_FLOATBUS_EN, floatbus_data=FF.
